// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared state type, Ethernet framing constants and IFG helper
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        DRAIN,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;

    // Effective gap in byte slots: the programmed value, never below the floor.
    function automatic logic [7:0] ifg_effective(input logic [7:0] ifg_delay, input int ifg_min);
        logic [7:0] floor_v;
        if (ifg_min <= 0) begin
            floor_v = 8'd0;
        end else if (ifg_min > 255) begin
            floor_v = 8'hFF;
        end else begin
            floor_v = 8'(ifg_min);
        end
        return (ifg_delay > floor_v) ? ifg_delay : floor_v;
    endfunction

endpackage

// File: rtl/eth_axis_tx_framer_if.sv
// rtl/eth_axis_tx_framer_if.sv - 8-bit AXI-Stream payload bus feeding the TX framer
interface eth_axis_tx_framer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - combinational IEEE 802.3 CRC32 update by one byte, LSB first
module eth_crc32_byte
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_axis_tx_framer.sv
// rtl/eth_axis_tx_framer.sv - AXIS to GMII-style byte framer: preamble, SFD, pad, FCS, IFG
// Optional statistics counters are built when ETH_TX_STATS_EN is defined.
module eth_axis_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int PREAMBLE_LEN     = 7,
    parameter int IFG_MIN          = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ce,
    input  logic [7:0]           ifg_delay,
    eth_axis_tx_framer_if.slave  s_axis,
    output logic [7:0]           txd,
    output logic                 tx_en,
    output logic                 tx_er,
    output logic                 start_packet,
    output logic                 error_underflow,
    output logic                 busy
`ifdef ETH_TX_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [31:0]          stat_bytes,
    output logic [15:0]          stat_errors
`endif
);

    localparam logic [15:0] PAD_TARGET = (MIN_FRAME_LENGTH > 4) ? 16'(MIN_FRAME_LENGTH - 4) : 16'd0;
    localparam logic [2:0]  PRE_LAST   = 3'(PREAMBLE_LEN - 1);
    localparam bit          PAD_EN     = (ENABLE_PADDING != 0);

    tx_state_t   state_q;
    logic [15:0] count_q;
    logic [2:0]  pre_cnt_q;
    logic [1:0]  fcs_idx_q;
    logic [7:0]  ifg_cnt_q;
    logic [31:0] crc_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic        start_q;
    logic        underflow_q;

    logic [15:0] count_inc;
    logic [7:0]  crc_data;
    logic [31:0] crc_d;
    logic [31:0] fcs_word;
    logic [7:0]  gap_load;

`ifdef ETH_TX_STATS_EN
    logic [31:0] stat_frames_q;
    logic [31:0] stat_bytes_q;
    logic [15:0] stat_errors_q;
`endif

    assign count_inc     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign crc_data      = (state_q == PAD) ? 8'h00 : s_axis.tdata;
    assign fcs_word      = ~crc_q;
    assign gap_load      = ifg_effective(ifg_delay, IFG_MIN);
    assign s_axis.tready = ce & ((state_q == PAYLOAD) | (state_q == DRAIN));

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (crc_data),
        .crc_out (crc_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            count_q     <= 16'd0;
            pre_cnt_q   <= 3'd0;
            fcs_idx_q   <= 2'd0;
            ifg_cnt_q   <= 8'd0;
            crc_q       <= ETH_CRC_INIT;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            start_q     <= 1'b0;
            underflow_q <= 1'b0;
`ifdef ETH_TX_STATS_EN
            stat_frames_q <= 32'd0;
            stat_bytes_q  <= 32'd0;
            stat_errors_q <= 16'd0;
`endif
        end else begin
            start_q     <= 1'b0;
            underflow_q <= 1'b0;
            if (ce) begin
                case (state_q)
                    IDLE: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                        if (s_axis.tvalid) begin
                            state_q   <= PREAMBLE;
                            start_q   <= 1'b1;
                            pre_cnt_q <= 3'd0;
                        end
                    end
                    PREAMBLE: begin
                        txd_q   <= ETH_PREAMBLE_BYTE;
                        tx_en_q <= 1'b1;
                        tx_er_q <= 1'b0;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_q <= SFD;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end
                    SFD: begin
                        txd_q   <= ETH_SFD_BYTE;
                        tx_en_q <= 1'b1;
                        tx_er_q <= 1'b0;
                        crc_q   <= ETH_CRC_INIT;
                        count_q <= 16'd0;
                        state_q <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        tx_en_q <= 1'b1;
                        if (s_axis.tvalid) begin
                            txd_q   <= s_axis.tdata;
                            tx_er_q <= 1'b0;
                            crc_q   <= crc_d;
                            count_q <= count_inc;
                            if (s_axis.tlast) begin
                                if (s_axis.tuser) begin
                                    tx_er_q   <= 1'b1;
                                    ifg_cnt_q <= gap_load;
                                    state_q   <= IFG;
`ifdef ETH_TX_STATS_EN
                                    stat_errors_q <= stat_errors_q + 16'd1;
`endif
                                end else if (PAD_EN && (count_inc < PAD_TARGET)) begin
                                    state_q <= PAD;
                                end else begin
                                    fcs_idx_q <= 2'd0;
                                    state_q   <= FCS;
                                end
                            end
                        end else begin
                            // Source starved mid-frame: poison this slot, then discard the rest.
                            txd_q       <= 8'h00;
                            tx_er_q     <= 1'b1;
                            underflow_q <= 1'b1;
                            state_q     <= DRAIN;
`ifdef ETH_TX_STATS_EN
                            stat_errors_q <= stat_errors_q + 16'd1;
`endif
                        end
                    end
                    DRAIN: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                        if (s_axis.tvalid && s_axis.tlast) begin
                            ifg_cnt_q <= gap_load;
                            state_q   <= IFG;
                        end
                    end
                    PAD: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b1;
                        tx_er_q <= 1'b0;
                        crc_q   <= crc_d;
                        count_q <= count_inc;
                        if (count_inc >= PAD_TARGET) begin
                            fcs_idx_q <= 2'd0;
                            state_q   <= FCS;
                        end
                    end
                    FCS: begin
                        txd_q     <= fcs_word[{fcs_idx_q, 3'b000} +: 8];
                        tx_en_q   <= 1'b1;
                        tx_er_q   <= 1'b0;
                        fcs_idx_q <= fcs_idx_q + 2'd1;
                        if (fcs_idx_q == 2'd3) begin
                            ifg_cnt_q <= gap_load;
                            state_q   <= IFG;
`ifdef ETH_TX_STATS_EN
                            stat_frames_q <= stat_frames_q + 32'd1;
                            stat_bytes_q  <= stat_bytes_q + {16'd0, count_q} + 32'd4;
`endif
                        end
                    end
                    IFG: begin
                        txd_q   <= 8'h00;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                        // The IDLE slot that launches the next frame is the final gap slot.
                        if (ifg_cnt_q <= 8'd2) begin
                            state_q <= IDLE;
                        end else begin
                            ifg_cnt_q <= ifg_cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign txd             = txd_q;
    assign tx_en           = tx_en_q;
    assign tx_er           = tx_er_q;
    assign start_packet    = start_q;
    assign error_underflow = underflow_q;
    assign busy            = (state_q != IDLE);

`ifdef ETH_TX_STATS_EN
    assign stat_frames = stat_frames_q;
    assign stat_bytes  = stat_bytes_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_eth_axis_tx_framer.sv
// tb/tb_eth_axis_tx_framer.sv - table-driven and randomized bench for eth_axis_tx_framer
`timescale 1ns/1ps
module tb_eth_axis_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       ce;
    logic [7:0] ifg_delay;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser;
    logic       sel;

    eth_axis_tx_framer_if ifa ();
    eth_axis_tx_framer_if ifb ();

    assign ifa.tdata  = tdata;
    assign ifa.tvalid = tvalid & ~sel;
    assign ifa.tlast  = tlast;
    assign ifa.tuser  = tuser;
    assign ifb.tdata  = tdata;
    assign ifb.tvalid = tvalid & sel;
    assign ifb.tlast  = tlast;
    assign ifb.tuser  = tuser;

    logic [7:0] txd_a, txd_b;
    logic en_a, en_b, er_a, er_b, sp_a, sp_b, uf_a, uf_b, busy_a, busy_b;
`ifdef ETH_TX_STATS_EN
    logic [31:0] sf_a, sb_a, sf_b, sb_b;
    logic [15:0] se_a, se_b;
`endif

    eth_axis_tx_framer dut_a (
        .clk(clk), .resetn(resetn), .ce(ce), .ifg_delay(ifg_delay), .s_axis(ifa),
        .txd(txd_a), .tx_en(en_a), .tx_er(er_a), .start_packet(sp_a),
        .error_underflow(uf_a), .busy(busy_a)
`ifdef ETH_TX_STATS_EN
        , .stat_frames(sf_a), .stat_bytes(sb_a), .stat_errors(se_a)
`endif
    );

    eth_axis_tx_framer #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(0)) dut_b (
        .clk(clk), .resetn(resetn), .ce(ce), .ifg_delay(ifg_delay), .s_axis(ifb),
        .txd(txd_b), .tx_en(en_b), .tx_er(er_b), .start_packet(sp_b),
        .error_underflow(uf_b), .busy(busy_b)
`ifdef ETH_TX_STATS_EN
        , .stat_frames(sf_b), .stat_bytes(sb_b), .stat_errors(se_b)
`endif
    );

    logic [7:0] m_txd;
    logic m_en, m_er, m_sp, m_uf, m_busy, m_tready;
    assign m_txd    = sel ? txd_b  : txd_a;
    assign m_en     = sel ? en_b   : en_a;
    assign m_er     = sel ? er_b   : er_a;
    assign m_sp     = sel ? sp_b   : sp_a;
    assign m_uf     = sel ? uf_b   : uf_a;
    assign m_busy   = sel ? busy_b : busy_a;
    assign m_tready = sel ? ifb.tready : ifa.tready;

    typedef struct packed { logic [7:0] data; logic last; logic user; } beat_t;
    typedef struct packed { logic en; logic er; logic [7:0] d; } slot_t;
    typedef struct { int sel; int len; int kind; int ce_div; int exp_slots; logic [31:0] exp_fcs; bit chk_fcs; } vec_t;

    beat_t      src[$];
    slot_t      cap[$];
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    int         r_start[$];
    int         r_len[$];

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt, uf_cnt, cyc, ce_div, drop_idx, acc_cnt;
    bit dropped;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        if (src.size() > 0 && !(acc_cnt == drop_idx && !dropped)) begin
            tvalid = 1'b1;
            tdata  = src[0].data;
            tlast  = src[0].last;
            tuser  = src[0].user;
        end else begin
            tvalid = 1'b0;
            tdata  = 8'h00;
            tlast  = 1'b0;
            tuser  = 1'b0;
        end
    endtask

    // One clock: sample handshake mid-cycle, capture the slot after the edge, drive next inputs.
    task automatic tick();
        logic ce_app, hs;
        slot_t s;
        #4;
        ce_app = ce;
        hs     = ce & tvalid & m_tready;
        @(posedge clk);
        #1;
        if (ce_app) begin
            s.en = m_en; s.er = m_er; s.d = m_txd;
            cap.push_back(s);
        end
        if (m_sp) start_cnt++;
        if (m_uf) uf_cnt++;
        if (ce_app && acc_cnt == drop_idx && !dropped) dropped = 1'b1;
        if (hs) begin
            src.delete(0);
            acc_cnt++;
        end
        cyc++;
        ce = ((cyc % ce_div) == 0);
        drive();
    endtask

    task automatic run_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((src.size() > 0 || m_busy) && n < budget);
        check({name, " completes"}, (src.size() > 0 || m_busy) ? 1 : 0, 0);
    endtask

    task automatic start_run();
        cap.delete();
        src.delete();
        start_cnt = 0; uf_cnt = 0; acc_cnt = 0; drop_idx = -1; dropped = 1'b0;
    endtask

    task automatic rand_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic load_frame(input bit abort);
        beat_t b;
        for (int i = 0; i < pay.size(); i++) begin
            b.data = pay[i];
            b.last = (i == pay.size() - 1);
            b.user = abort && b.last;
            src.push_back(b);
        end
    endtask

    function automatic logic [31:0] crc_ref(input int from);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = from; i < exp_q.size(); i++) begin
            c = c ^ {24'd0, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Reference frame: 7 preamble, SFD, payload, zero pad to 60 bytes if padded, FCS LSB first.
    task automatic build_exp(input bit padded, input bit with_fcs);
        logic [31:0] f;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < pay.size(); i++) exp_q.push_back(pay[i]);
        if (with_fcs) begin
            while (padded && (exp_q.size() - 8) < 60) exp_q.push_back(8'h00);
            f = crc_ref(8);
            for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
        end
    endtask

    task automatic find_runs();
        r_start.delete();
        r_len.delete();
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i].en) begin
                if (i == 0 || !cap[i-1].en) begin
                    r_start.push_back(i);
                    r_len.push_back(1);
                end else begin
                    r_len[r_len.size()-1]++;
                end
            end
        end
    endtask

    task automatic check_frame(input string name, input int k, input int exp_slots, input bit er_last);
        int len, st, bad, ers;
        len = (r_len.size() > k) ? r_len[k] : 0;
        st  = (r_start.size() > k) ? r_start[k] : 0;
        check({name, " span"}, len, exp_slots);
        bad = (len > exp_q.size()) ? len - exp_q.size() : exp_q.size() - len;
        ers = 0;
        for (int i = 0; i < len && i < exp_q.size(); i++) begin
            if (cap[st+i].d !== exp_q[i]) bad++;
            if (cap[st+i].er) ers++;
        end
        check({name, " bytes_bad"}, bad, 0);
        check({name, " er_slots"}, ers, er_last ? 1 : 0);
        if (er_last && len > 0) check({name, " er_on_last"}, cap[st+len-1].er, 1);
    endtask

    vec_t vt[7];

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gap;
        logic [31:0] fw;
`ifdef ETH_TX_STATS_EN
        logic [31:0] f0, b0;
        logic [15:0] e0;
`endif
        vt[0] = '{1, 9,  0, 1,  21, 32'hCBF43926, 1'b1};
        vt[1] = '{0, 1,  1, 1,  72, 32'h0, 1'b0};
        vt[2] = '{0, 9,  0, 1,  72, 32'h0, 1'b0};
        vt[3] = '{0, 60, 2, 1,  72, 32'h0, 1'b0};
        vt[4] = '{0, 61, 2, 1,  73, 32'h0, 1'b0};
        vt[5] = '{0, 1,  1, 10, 72, 32'h0, 1'b0};
        vt[6] = '{1, 9,  0, 10, 21, 32'hCBF43926, 1'b1};

        resetn = 1'b0; ce = 1'b1; ce_div = 1; cyc = 0; sel = 1'b0; ifg_delay = 8'd12;
        tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0;
        start_run();
        repeat (3) @(posedge clk);
        #1;
        check("reset txd", m_txd, 0);
        check("reset tx_en", m_en, 0);
        check("reset tx_er", m_er, 0);
        check("reset tready", m_tready, 0);
        check("reset pulses", {m_sp, m_uf}, 0);
        check("reset busy", m_busy, 0);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a payload.
        sel = 1'b0; ce_div = 1;
        start_run(); rand_pay(40); load_frame(1'b0); drive();
        n = 0;
        while (acc_cnt < 5 && n < 200) begin tick(); n++; end
        check("midreset tx_en before", m_en, 1);
        #2 resetn = 1'b0;
        #1;
        check("midreset tx_en", m_en, 0);
        check("midreset busy", m_busy, 0);
        check("midreset tready", m_tready, 0);
        src.delete(); drive();
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            sel = 1'(vt[v].sel); ce_div = vt[v].ce_div;
            start_run();
            pay.delete();
            for (int i = 0; i < vt[v].len; i++) begin
                if (vt[v].kind == 0) pay.push_back(8'h31 + 8'(i));
                else if (vt[v].kind == 1) pay.push_back(8'hAB);
                else pay.push_back(8'($urandom_range(0, 255)));
            end
`ifdef ETH_TX_STATS_EN
            f0 = sf_a; b0 = sb_a;
`endif
            load_frame(1'b0); drive();
            run_done($sformatf("vec%0d", v), 3000);
            build_exp(vt[v].sel == 0, 1'b1);
            find_runs();
            check($sformatf("vec%0d runs", v), r_start.size(), 1);
            check_frame($sformatf("vec%0d", v), 0, vt[v].exp_slots, 1'b0);
            check($sformatf("vec%0d start_packet", v), start_cnt, 1);
            if (vt[v].chk_fcs && r_len.size() > 0 && r_len[0] >= 4) begin
                for (int i = 0; i < 4; i++) fw[8*i +: 8] = cap[r_start[0] + r_len[0] - 4 + i].d;
                check($sformatf("vec%0d fcs", v), fw, vt[v].exp_fcs);
            end
`ifdef ETH_TX_STATS_EN
            if (vt[v].sel == 0) begin
                check($sformatf("vec%0d stat_frames", v), sf_a - f0, 1);
                check($sformatf("vec%0d stat_bytes", v), sb_a - b0, exp_q.size() - 8);
            end
`endif
        end

        // Back-to-back frames: gap clamped to the floor, then an explicit larger gap.
        for (int g = 0; g < 2; g++) begin
            ifg_delay = (g == 0) ? 8'd4 : 8'd20;
            sel = 1'b0; ce_div = 1;
            start_run();
            rand_pay(60); load_frame(1'b0);
            rand_pay(60); load_frame(1'b0);
            drive();
            run_done("b2b", 4000);
            find_runs();
            check("b2b runs", r_start.size(), 2);
            gap = (r_start.size() >= 2) ? r_start[1] - (r_start[0] + r_len[0]) : -1;
            check((g == 0) ? "gap clamp" : "gap 20", gap, (g == 0) ? 12 : 20);
            build_exp(1'b1, 1'b1);
            check_frame("b2b second", 1, 72, 1'b0);
        end
        ifg_delay = 8'd12;

        // Underflow: tvalid withheld once after 10 accepted payload bytes.
        sel = 1'b0; ce_div = 1;
        start_run(); rand_pay(40); load_frame(1'b0); drop_idx = 10; drive();
`ifdef ETH_TX_STATS_EN
        e0 = se_a; f0 = sf_a;
`endif
        run_done("underflow", 3000);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 10; i++) exp_q.push_back(pay[i]);
        exp_q.push_back(8'h00);
        find_runs();
        check("underflow runs", r_start.size(), 1);
        check_frame("underflow", 0, 19, 1'b1);
        check("underflow pulses", uf_cnt, 1);
        check("underflow drained", acc_cnt, 40);
`ifdef ETH_TX_STATS_EN
        check("underflow stat_errors", se_a - e0, 1);
        check("underflow stat_frames", sf_a - f0, 0);
`endif

        // Abort: tlast with tuser on payload byte 30.
        start_run(); rand_pay(30); load_frame(1'b1); drive();
`ifdef ETH_TX_STATS_EN
        e0 = se_a; f0 = sf_a;
`endif
        run_done("abort", 3000);
        build_exp(1'b0, 1'b0);
        find_runs();
        check("abort runs", r_start.size(), 1);
        check_frame("abort", 0, 38, 1'b1);
        check("abort no underflow", uf_cnt, 0);
`ifdef ETH_TX_STATS_EN
        check("abort stat_errors", se_a - e0, 1);
        check("abort stat_frames", sf_a - f0, 0);
`endif

        for (int r = 0; r < 6; r++) begin
            sel = 1'($urandom_range(0, 1));
            ce_div = int'($urandom_range(1, 3));
            start_run();
            rand_pay(int'($urandom_range(1, 90)));
            load_frame(1'b0); drive();
            run_done("rand", 3000);
            build_exp(sel == 1'b0, 1'b1);
            find_runs();
            check($sformatf("rand%0d runs", r), r_start.size(), 1);
            check_frame($sformatf("rand%0d", r), 0, exp_q.size(), 1'b0);
            check($sformatf("rand%0d start_packet", r), start_cnt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_axis_tx_framer.md
Name: eth_axis_tx_framer

Overview:
Parametrised AXI-Stream-to-byte-stream Ethernet transmit framer. It is the successor to the fixed 100 Mb MII transmit path.
- Takes 8-bit AXIS payload (destination MAC through last payload byte).
- Emits preamble, SFD, payload, zero padding, CRC32 FCS and a runtime-programmable inter-frame gap on a GMII-style byte interface.
- A clock enable (ce) paces the block, so one clock domain serves 10, 100 and 1000 Mb rates.
- Sits between the UDP/IP stack's AXIS output and the PHY-side nibble/byte serialiser.

Parameters:
- ENABLE_PADDING, 1, 1 = pad short frames with 0x00 up to MIN_FRAME_LENGTH.
- MIN_FRAME_LENGTH, 64, minimum frame length in bytes, including 4-byte FCS; legal range 18..1518.
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD; legal range 1..7.
- IFG_MIN, 12, floor applied to ifg_delay, in bytes.

Ports:
- clk  in  1  single block clock
- resetn  in  1  asynchronous active-low reset
- ce  in  1  byte-slot enable; state advances and txd updates only when ce=1
- ifg_delay  in  8  inter-frame gap in bytes; effective gap = max(ifg_delay, IFG_MIN); sampled on entry to IFG
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- s_axis_tlast  in  1  last payload byte
- s_axis_tuser  in  1  on the tlast beat: abort the frame
- txd  out  8  transmit byte
- tx_en  out  1  transmit enable
- tx_er  out  1  transmit error
- start_packet  out  1  one-clk pulse at first preamble byte
- error_underflow  out  1  one-clk pulse when an underflow is detected
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous): state=IDLE; txd=0, tx_en=0, tx_er=0, s_axis_tready=0, start_packet=0, error_underflow=0, busy=0; CRC=0xFFFFFFFF.
- Registered outputs. txd/tx_en/tx_er change only in a clk cycle where ce=1, and hold otherwise. Pulse outputs last exactly one clk.

State machine:
- IDLE: stays here with tx_en=0. On ce and s_axis_tvalid, moves to PREAMBLE and pulses start_packet. First byte appears at txd on the next ce slot, giving 1 ce-slot latency.
- PREAMBLE: PREAMBLE_LEN slots of 0x55, then SFD.
- SFD: 0xD5 for one slot; CRC reset to 0xFFFFFFFF; then PAYLOAD.
- PAYLOAD:
  - s_axis_tready = ce, combinational with state; a beat is accepted only when ce & tvalid & tready.
  - Each accepted byte is driven on txd and folded into the CRC; the byte counter increments (16-bit, saturating).
  - tlast & tuser=1 (abort): drive tx_er=1 for that slot, skip PAD/FCS, go to IFG.
  - tlast & tuser=0: if ENABLE_PADDING and count < MIN_FRAME_LENGTH-4, go to PAD; otherwise go to FCS.
  - tvalid=0 in a ce slot (underflow): drive tx_er=1 with txd=0 and pulse error_underflow. Then go to DRAIN, which discards input with tready=1 up to and including tlast, while tx_en stays low. Then go to IFG.
- PAD: 0x00 bytes folded into the CRC until count = MIN_FRAME_LENGTH-4; then FCS.
- FCS: 4 slots of ~CRC, least significant byte first.
- IFG: tx_en=0 for the effective gap in ce slots, then IDLE. Back-to-back frames therefore keep an exact gap.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, one byte per update, LSB-first.
- ce=0 in any state: full hold; no counter or CRC update and no AXIS acceptance.
- ifg_delay changing mid-frame has no effect until the next IFG entry.

Optional Feature:
- ETH_TX_STATS_EN defined: adds outputs stat_frames[31:0], stat_bytes[31:0] and stat_errors[15:0].
  - All reset to 0 and wrap on overflow.
  - stat_frames increments on each FCS completion.
  - stat_bytes adds the on-wire frame length (payload + pad + FCS) at FCS completion.
  - stat_errors increments on each abort or underflow.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package eth_tx_pkg holds:
  - state enum tx_state_t (IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, PAD, FCS, IFG);
  - constants ETH_PREAMBLE_BYTE=8'h55, ETH_SFD_BYTE=8'hD5, ETH_CRC_INIT=32'hFFFFFFFF, ETH_CRC_POLY=32'hEDB88320.
- Sub-module eth_crc32_byte: combinational next-CRC from (crc_in[31:0], data[7:0]); shared with the future receive checker.

Test Plan:
- ENABLE_PADDING=0, MIN_FRAME_LENGTH=0, payload ASCII "123456789", ce=1 → 7×0x55, 0xD5, 31..39, FCS bytes 0x26 0x39 0xF4 0xCB; tx_en high for exactly 21 slots.
- Defaults, one-byte payload 0xAB with tlast → 0xAB followed by 59×0x00 and 4 FCS bytes matching the reference model; tx_en spans 72 slots.
- Back-to-back 60-byte frames with ifg_delay=4 → gap clamped to 12 slots; ifg_delay=20 → gap of exactly 20 slots.
- tvalid dropped at payload byte 10 → tx_er=1 in that slot, one error_underflow pulse, no FCS, remaining input drained through tlast, IFG then IDLE.
- tlast+tuser on byte 30 → tx_er=1 on that slot, no PAD or FCS; ETH_TX_STATS_EN build shows stat_errors=1, stat_frames=0.
- ce toggled 1-in-10 (100 Mb pacing), plus resetn asserted mid-PAYLOAD → byte sequence is identical to the ce=1 run; reset immediately clears tx_en and returns to IDLE.
